// File: rtl/imem_loader.sv
// Host program loader: parses framed byte stream (sync, length, LE data words, XOR checksum),
// writes words into the instruction memory and holds the CPU in reset until a valid frame lands.
module imem_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int IMEM_DEPTH    = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic                     cpu_rst,
    output logic                     load_done,
    output logic                     err,
    output logic [2:0]               dbg_state
);

    // Byte handshake: a byte transfers on a rising clk edge where byte_valid && byte_ready;
    // byte_ready drops only in WR, so a held byte is taken the cycle after WR.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_WR   = 3'd4,
        S_CHK  = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    state_t                   state_q, state_d;
    logic [15:0]              len_q, len_d;
    logic [DATA_WIDTH-1:0]    word_q, word_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [15:0]              word_idx_q, word_idx_d;
    logic [7:0]               xor_q, xor_d;
    logic                     imem_we_q, imem_we_d;
    logic [ADDRESS_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0]    imem_wdata_q, imem_wdata_d;

    logic                     accept;
    logic [16:0]              len_new;
    logic [DATA_WIDTH-1:0]    word_shift;
    logic [15:0]              word_idx_inc;

    assign accept       = byte_valid && byte_ready;
    assign len_new      = {1'b0, byte_data, len_q[7:0]};
    // Little-endian: each new byte enters at the top and older bytes slide down.
    assign word_shift   = {byte_data, word_q[DATA_WIDTH-1:8]};
    assign word_idx_inc = word_idx_q + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_q       <= '0;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            xor_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_q       <= word_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            xor_q        <= xor_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_d       = word_q;
        byte_cnt_d   = byte_cnt_q;
        word_idx_d   = word_idx_q;
        xor_d        = xor_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && byte_data == SYNC_BYTE) begin
                    state_d    = S_LEN0;
                    xor_d      = '0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d[7:0] = byte_data;
                    xor_d      = xor_q ^ byte_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d[15:8] = byte_data;
                    xor_d       = xor_q ^ byte_data;
                    if (len_new > 17'(IMEM_DEPTH)) begin
                        state_d = S_ERR;
                    end else if (len_new == 17'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d      = xor_q ^ byte_data;
                    word_d     = word_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Write port registers load here so they line up with the WR cycle.
                    if (byte_cnt_q == 2'd3) begin
                        state_d      = S_WR;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ADDRESS_WIDTH'({word_idx_q, 2'b00});
                        imem_wdata_d = word_shift;
                    end
                end
            end
            S_WR: begin
                word_idx_d = word_idx_inc;
                state_d    = (word_idx_inc < len_q) ? S_DATA : S_CHK;
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (byte_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign byte_ready = (state_q != S_WR);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = (state_q != S_DONE);
    assign load_done  = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame table plus hand sequences for reset and max-length frames.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        err;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic watch_rst = 1'b0;
    logic [63:0] exp_q[$];

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor and scoreboard
    always @(negedge clk) begin
        if (rst) check("ready_vs_wr", {63'd0, byte_ready}, {63'd0, ~imem_we});
        if (watch_rst) check("cpu_rst_held", {63'd0, cpu_rst}, 64'd1);
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {imem_addr, imem_wdata}, 64'd0);
            end else begin
                check("write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        @(negedge clk);
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic done, input logic e);
        check({tag, "_load_done"}, {63'd0, load_done}, {63'd0, done});
        check({tag, "_err"}, {63'd0, err}, {63'd0, e});
        check({tag, "_cpu_rst"}, {63'd0, cpu_rst}, {63'd0, ~done});
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct packed {
        logic [127:0] bytes;
        logic [7:0]   nbytes;
        logic [1:0]   nwr;
        logic [63:0]  wdata;
        logic         exp_done;
        logic         exp_err;
        logic         rand_gap;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int idx);
        int gap;
        for (int k = 0; k < int'(v.nwr); k++)
            exp_q.push_back({32'(k * 4), v.wdata[k*32 +: 32]});
        for (int j = 0; j < int'(v.nbytes); j++) begin
            gap = v.rand_gap ? int'($urandom_range(0, 3)) : 0;
            send_byte(v.bytes[(int'(v.nbytes) - 1 - j) * 8 +: 8], gap);
        end
        #1;
        check_status($sformatf("vec%0d", idx), v.exp_done, v.exp_err);
        idle_bus();
    endtask

    initial begin
        logic [7:0]  chk;
        logic [31:0] w;

        // Good 2-word frame, continuous valid
        vecs[0] = '{128'hA5_02_00_13_00_50_00_93_00_10_00_C2, 8'd12, 2'd2,
                    {32'h00100093, 32'h00500013}, 1'b1, 1'b0, 1'b0};
        // Same frame, bad checksum
        vecs[1] = '{128'hA5_02_00_13_00_50_00_93_00_10_00_C3, 8'd12, 2'd2,
                    {32'h00100093, 32'h00500013}, 1'b0, 1'b1, 1'b1};
        // Correct frame after error, random gaps
        vecs[2] = '{128'hA5_02_00_13_00_50_00_93_00_10_00_C2, 8'd12, 2'd2,
                    {32'h00100093, 32'h00500013}, 1'b1, 1'b0, 1'b1};
        // N = 1025: rejected at LEN_HI
        vecs[3] = '{128'hA5_01_04, 8'd3, 2'd0, 64'd0, 1'b0, 1'b1, 1'b0};
        // N = 0 with matching checksum
        vecs[4] = '{128'hA5_00_00_00, 8'd4, 2'd0, 64'd0, 1'b1, 1'b0, 1'b0};
        // Junk before sync, then 1-word frame
        vecs[5] = '{128'h13_00_A5_01_00_78_56_34_12_09, 8'd10, 2'd1,
                    {32'd0, 32'h12345678}, 1'b1, 1'b0, 1'b1};
        // N = 0 with wrong checksum
        vecs[6] = '{128'hA5_00_00_01, 8'd4, 2'd0, 64'd0, 1'b0, 1'b1, 1'b0};

        #1 rst = 1'b0;
        #3;
        check("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        check("rst_imem_we", {63'd0, imem_we}, 64'd0);
        check("rst_load_done", {63'd0, load_done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_byte_ready", {63'd0, byte_ready}, 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Bytes without sync are dropped
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        idle_bus();
        repeat (2) @(negedge clk);
        check("nosync_state", 64'(dbg_state), 64'd0);
        check_status("nosync", 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Max-length frame: N = IMEM_DEPTH, last write at 0xFFC
        chk = 8'h00 ^ 8'h04;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 1024; i++) begin
            w = 32'(i) * 32'h9E3779B1 + 32'h1;
            exp_q.push_back({32'(i * 4), w});
            for (int b = 0; b < 4; b++) begin
                chk = chk ^ w[b*8 +: 8];
                send_byte(w[b*8 +: 8], 0);
            end
        end
        send_byte(chk, 0);
        #1;
        check_status("maxlen", 1'b1, 1'b0);
        idle_bus();

        // Reset mid-frame after 2 data bytes
        run_vec(vecs[0], 100);
        send_byte(8'hA5, 0);
        #1;
        check("resync_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        check("resync_load_done", {63'd0, load_done}, 64'd0);
        watch_rst = 1'b1;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        check("midrst_imem_we", {63'd0, imem_we}, 64'd0);
        check("midrst_addr", {32'd0, imem_addr}, 64'd0);
        check("midrst_wdata", {32'd0, imem_wdata}, 64'd0);
        check("midrst_load_done", {63'd0, load_done}, 64'd0);
        check("midrst_err", {63'd0, err}, 64'd0);
        check("midrst_byte_ready", {63'd0, byte_ready}, 64'd1);
        check("midrst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        send_byte(8'hA5, 1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 2);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 1);
        send_byte(8'hDE, 0);
        watch_rst = 1'b0;
        send_byte(8'h23, 0);
        #1;
        check_status("after_rst", 1'b1, 1'b0);
        check("after_rst_addr", {32'd0, imem_addr}, 64'd0);
        check("after_rst_wdata", {32'd0, imem_wdata}, {32'd0, 32'hDEADBEEF});
        idle_bus();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Host-side program loader that writes the barrel CPU's instruction memory, which the fetch stage reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one word write per assembled word into the imem write port, and holds the CPU in reset until a frame completes with a correct checksum.
- Sits between the host link (UART/JTAG byte adapter) and the imem write port and CPU reset at the top level.

Parameters:
- DATA_WIDTH, 32: instruction word width; fixed at 32 (4 bytes per word).
- ADDRESS_WIDTH, 32: imem byte-address width.
- IMEM_DEPTH, 1024: instruction memory capacity in words; maximum legal word count.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- byte_valid  input  1  host byte available.
- byte_data  input  8  host byte.
- byte_ready  output  1  loader accepts byte; transfer occurs when byte_valid && byte_ready at a rising clk edge.
- imem_we  output  1  imem write strobe, one-cycle pulse per word.
- imem_addr  output  ADDRESS_WIDTH  imem byte address (word index * 4).
- imem_wdata  output  DATA_WIDTH  assembled instruction word.
- cpu_rst  output  1  active-high reset/clear to the CPU core.
- load_done  output  1  level; valid program loaded, CPU released.
- err  output  1  level; last frame rejected.

Behaviour:
- Frame format: sync byte 0xA5, then LEN_LO, then LEN_HI. LEN = word count N (16-bit). Then N×4 data bytes, least-significant byte first per word. Then CHK = XOR of every byte after sync, excluding CHK itself.
- FSM states and transitions:
  - IDLE: accepted 0xA5 -> LEN0; any other byte is dropped.
  - LEN0 -> LEN1 on an accepted byte.
  - LEN1, on an accepted byte:
    - if N > IMEM_DEPTH -> ERR, with no writes;
    - if N == 0 -> CHK;
    - otherwise -> DATA.
  - DATA: shift bytes into the word register. On the 4th byte -> WR.
  - WR: lasts one cycle, then:
    - -> DATA if words written < N;
    - -> CHK if all N words are written.
  - CHK: accepted byte:
    - == running XOR -> DONE;
    - otherwise -> ERR.
  - DONE and ERR: accepted 0xA5 -> LEN0 and starts a new frame. Other bytes are dropped.
- byte_ready = 1 in every state except WR, where it is 0. A held byte is accepted on the cycle after WR.
- imem_we is registered:
  - high exactly during WR;
  - imem_addr = {word_idx, 2'b00}, where word_idx starts at 0 per frame and increments after each WR;
  - imem_wdata holds the assembled word during WR;
  - addr and wdata hold their last values otherwise.
- cpu_rst:
  - = 1 in all states except DONE;
  - deasserts the cycle after the CHK byte is accepted with a match;
  - reasserts the cycle after a new 0xA5 is accepted in DONE.
- load_done = 1 only in DONE. err = 1 only in ERR; cleared when a new sync byte is accepted.
- Running XOR, word_idx and the byte counter clear when 0xA5 is accepted in IDLE, DONE or ERR.
- Writes already committed to imem before an ERR are not undone. The CPU stays in reset, so they are never executed.
- Reset (asynchronous, rst = 0), at any time including mid-frame:
  - state = IDLE; partial word, counters and XOR are discarded;
  - cpu_rst = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0;
  - load_done = 0, err = 0, byte_ready = 1.
- Length uses full 16-bit compare; N = IMEM_DEPTH is legal and fills the last address (IMEM_DEPTH-1)*4.

Test Plan:
- Reset: hold rst = 0 mid-stream -> cpu_rst = 1, imem_we = 0, load_done = 0, err = 0, byte_ready = 1; after release, bytes 0x13 0x00 (no sync) are dropped and no write occurs.
- Frame A5 02 00 13 00 50 00 93 00 10 00 C2 -> imem_we pulses with (addr 0x0, data 0x00500013) then (addr 0x4, data 0x00100093); load_done = 1 and cpu_rst = 0 one cycle after C2 is accepted.
- Same frame with CHK = C3 -> both writes occur, err = 1, cpu_rst stays 1, load_done = 0. A following correct frame clears err and reaches DONE.
- A5 01 04 (N = 1025) -> err = 1 after LEN_HI, no imem_we. A5 00 00 00 -> load_done = 1 with zero writes.
- Host keeps byte_valid high continuously -> byte_ready = 0 exactly in each WR cycle; no byte is lost or duplicated and data matches. Randomized valid gaps give identical writes.
- Async reset after 2 data bytes of word 1, then a fresh 1-word frame -> partial word discarded; the write goes to addr 0x0 with the new data; cpu_rst was held high throughout.
